shift_register_capture: RTL and testbench

- Serial-in, parallel-out capture register: the receive direction of the SoC→JTAG shift-out path.
- Deserializes a JTAG-side bit stream, LSB first, into a LENGTH-bit word.
- Presents the word to the SoC with a valid/ack handshake.
- Flags overrun when a new word completes before the previous one was acknowledged.

---
 rtl/shift_register_pkg.sv | 8 +
 rtl/shift_register_capture.sv | 88 ++++++++
 tb/tb_shift_register_capture.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared constants for the JTAG shift-out / capture path.
// Keeps the shift-out block, the capture block and their benches on one word length.
package shift_register_pkg;

  // Default word width for the JTAG <-> SoC shift path
  localparam int unsigned SR_DEFAULT_LENGTH = 8;

endpackage : shift_register_pkg

// File: rtl/shift_register_capture.sv
// Serial-in, parallel-out capture register for the SoC <- JTAG direction.
// Collects a LSB-first bit stream into a LENGTH-bit word, then hands it to
// the SoC through a valid/ack handshake. A sticky overrun flag records a
// completed word replacing one the SoC never acknowledged.
module shift_register_capture
  import shift_register_pkg::*;
#(
  parameter int LENGTH = SR_DEFAULT_LENGTH,
  localparam int CNT_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              jtagInput,
  input  logic              abort,
  input  logic              socAck,
  output logic [LENGTH-1:0] socInput,
  output logic              socValid,
  output logic              overrun,
  output logic [CNT_W-1:0]  bitCount
);

  logic [LENGTH-1:0] sregQ, sregD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [LENGTH-1:0] wordQ, wordD;
  logic              validQ, validD;
  logic              overrunQ, overrunD;

  logic [LENGTH-1:0] shiftedWord;
  logic              lastBit;
  logic              complete;

  // The completing shift is the one that lands while the counter sits at
  // LENGTH-1; an abort in the same cycle suppresses it entirely.
  assign shiftedWord = {jtagInput, sregQ[LENGTH-1:1]};
  assign lastBit     = (cntQ == CNT_W'(LENGTH - 1));
  assign complete    = shift && !abort && lastBit;

  // Next-state logic for the shadow register, bit counter and SoC-side flags
  always_comb begin
    sregD    = sregQ;
    cntD     = cntQ;
    wordD    = wordQ;
    validD   = validQ;
    overrunD = overrunQ;

    if (abort) begin
      sregD = '0;
      cntD  = '0;
    end else if (shift) begin
      sregD = shiftedWord;
      cntD  = lastBit ? '0 : cntQ + CNT_W'(1);
    end

    if (complete) begin
      wordD  = shiftedWord;
      validD = 1'b1;
      if (validQ && !socAck) begin
        overrunD = 1'b1;
      end
    end else if (socAck && validQ) begin
      validD = 1'b0;
    end
  end

  // State registers with synchronous reset overriding every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      sregQ    <= '0;
      cntQ     <= '0;
      wordQ    <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      sregQ    <= sregD;
      cntQ     <= cntD;
      wordQ    <= wordD;
      validQ   <= validD;
      overrunQ <= overrunD;
    end
  end

  assign socInput = wordQ;
  assign socValid = validQ;
  assign overrun  = overrunQ;
  assign bitCount = cntQ;

endmodule : shift_register_capture

// File: tb/tb_shift_register_capture.sv
// Self-checking bench for shift_register_capture: directed test-plan
// sequences followed by randomized traffic, all compared against a
// bit-queue reference model through a per-cycle scoreboard.
module tb_shift_register_capture;
  import shift_register_pkg::*;

  localparam int LEN = SR_DEFAULT_LENGTH;
  localparam int CW  = $clog2(LEN);

  typedef struct packed {
    logic [LEN-1:0] word;
    logic           valid;
    logic           ovr;
    logic [CW-1:0]  cnt;
  } expT;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           shift = 1'b0;
  logic           jtagInput = 1'b0;
  logic           abort = 1'b0;
  logic           socAck = 1'b0;
  logic [LEN-1:0] socInput;
  logic           socValid;
  logic           overrun;
  logic [CW-1:0]  bitCount;

  int errors = 0;
  int checks = 0;

  expT expQueue[$];

  // Reference model state: bits received so far in the current word
  bit             bitQ[$];
  logic [LEN-1:0] mWord = '0;
  logic           mValid = 1'b0;
  logic           mOvr = 1'b0;

  shift_register_capture #(.LENGTH(LEN)) dut (
    .clk(clk),
    .rst(rst),
    .shift(shift),
    .jtagInput(jtagInput),
    .abort(abort),
    .socAck(socAck),
    .socInput(socInput),
    .socValid(socValid),
    .overrun(overrun),
    .bitCount(bitCount)
  );

  always #5 clk = ~clk;

  // Model one clock edge from the rules: collect bits, assemble a word
  // once LENGTH have arrived, then apply handshake and overrun rules.
  task automatic modelUpdate(input bit r, input bit s, input bit b, input bit a, input bit k);
    bit             done;
    logic [LEN-1:0] w;
    done = 1'b0;
    w    = '0;
    if (r) begin
      bitQ.delete();
      mWord  = '0;
      mValid = 1'b0;
      mOvr   = 1'b0;
    end else begin
      if (a) begin
        bitQ.delete();
      end else if (s) begin
        bitQ.push_back(b);
        if (bitQ.size() == LEN) begin
          for (int i = 0; i < LEN; i++) w[i] = bitQ[i];
          bitQ.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (mValid && !k) mOvr = 1'b1;
        mValid = 1'b1;
        mWord  = w;
      end else if (k) begin
        mValid = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, predict the result, wait past the edge
  task automatic applyStimulus(input bit r, input bit s, input bit b, input bit a, input bit k);
    expT e;
    rst       = r;
    shift     = s;
    jtagInput = b;
    abort     = a;
    socAck    = k;
    modelUpdate(r, s, b, a, k);
    e.word  = mWord;
    e.valid = mValid;
    e.ovr   = mOvr;
    e.cnt   = CW'(bitQ.size());
    expQueue.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; shift = 1'b0; jtagInput = 1'b0; abort = 1'b0; socAck = 1'b0;
  endtask

  // Directed comparison against hand-derived constants
  task automatic checkOutput(input string name, input logic [LEN-1:0] w, input logic v,
                             input logic o, input logic [CW-1:0] c);
    checks++;
    if (socInput !== w || socValid !== v || overrun !== o || bitCount !== c) begin
      errors++;
      $display("[TB] FAIL %s: got word=%h valid=%b ovr=%b cnt=%0d, want word=%h valid=%b ovr=%b cnt=%0d",
               name, socInput, socValid, overrun, bitCount, w, v, o, c);
    end
  endtask

  task automatic shiftWord(input logic [LEN-1:0] w, input int gap, input bit ackLast);
    for (int i = 0; i < LEN; i++) begin
      applyStimulus(1'b0, 1'b1, w[i], 1'b0, ackLast && (i == LEN - 1));
      if (i != LEN - 1) repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Scoreboard monitor: every registered cycle presents a full output set
  always @(negedge clk) begin
    expT e;
    if (expQueue.size() != 0) begin
      e = expQueue.pop_front();
      checks++;
      if (socInput !== e.word || socValid !== e.valid || overrun !== e.ovr || bitCount !== e.cnt) begin
        errors++;
        $display("[TB] FAIL scoreboard @%0t: got word=%h valid=%b ovr=%b cnt=%0d, want word=%h valid=%b ovr=%b cnt=%0d",
                 $time, socInput, socValid, overrun, bitCount, e.word, e.valid, e.ovr, e.cnt);
      end
    end
  end

  initial begin
    int drain;

    // 1. Reset with noisy inputs
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 3'd0);

    // 2. Contiguous word 0x53
    for (int i = 0; i < LEN; i++) begin
      applyStimulus(1'b0, 1'b1, 1'((8'h53 >> i) & 1), 1'b0, 1'b0);
      if (i < LEN - 1) checkOutput("contigCount", 8'h00, 1'b0, 1'b0, CW'(i + 1));
    end
    checkOutput("contigWord", 8'h53, 1'b1, 1'b0, 3'd0);

    // 3. Ack, then gapped word 0xA5
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    shiftWord(8'hA5, 2, 1'b0);
    checkOutput("gappedWord", 8'hA5, 1'b1, 1'b0, 3'd0);

    // 4. Ack clears valid; stray ack is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ack", 8'hA5, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("strayAck", 8'hA5, 1'b0, 1'b0, 3'd0);

    // 5. Overrun, then same pair with ack on the completing edge
    shiftWord(8'h0F, 0, 1'b0);
    checkOutput("firstOfPair", 8'h0F, 1'b1, 1'b0, 3'd0);
    shiftWord(8'h84, 0, 1'b0);
    checkOutput("overrun", 8'h84, 1'b1, 1'b1, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resetClearsOvr", 8'h00, 1'b0, 1'b0, 3'd0);
    shiftWord(8'h0F, 0, 1'b0);
    shiftWord(8'h84, 0, 1'b1);
    checkOutput("ackOnComplete", 8'h84, 1'b1, 1'b0, 3'd0);

    // 6. Abort mid-word, then full word; reset mid-word
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("threeBits", 8'h84, 1'b1, 1'b0, 3'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("abort", 8'h84, 1'b1, 1'b0, 3'd0);
    shiftWord(8'h3C, 0, 1'b0);
    checkOutput("afterAbort", 8'h3C, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fiveBits", 8'h3C, 1'b1, 1'b1, 3'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midWordReset", 8'h00, 1'b0, 1'b0, 3'd0);

    // Abort on the completing shift must drop the word
    for (int i = 0; i < LEN - 1; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("abortOnLast", 8'h00, 1'b0, 1'b0, 3'd0);

    // Randomized traffic checked by the scoreboard
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 99) < 60,
                    1'($urandom),
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 20);
    end

    // Let the monitor drain, bounded
    drain = 0;
    while (expQueue.size() != 0 && drain < 10) begin
      @(negedge clk);
      #1;
      drain++;
    end
    checks++;
    if (expQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected cycles left unchecked, want 0", expQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_register_capture
